// File: rtl/pipe_flush_sequencer.sv
// Pipeline flush/hold sequencer: arbitrates bus stall, load-use stall and taken-jump flush,
// replaying a jump caught during a bus stall. Optional counters under FLUSH_PERF_CNT_EN.
module pipe_flush_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_stall,
  input  logic                  hazard_stall,
  input  logic                  jump_valid,
  input  logic                  jump_taken,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_hold,
  output logic                  pc_hold,
  output logic                  flush_pending
`ifdef FLUSH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t                state_q, state_d;
  logic                  jt;
  logic [NUM_STAGES-1:0] jmask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_jmask
      assign jmask[gi] = (gi < FLUSH_STAGES);
    end
  endgenerate

  assign jt = jump_valid & jump_taken;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    stage_flush   = '0;
    stage_hold    = '0;
    pc_hold       = 1'b0;
    flush_pending = 1'b0;
    if (rst) begin
      stage_flush = '1;
      state_d     = IDLE;
    end else begin
      flush_pending = (state_q == PEND);
      if (bus_stall) begin
        stage_hold = '1;
        pc_hold    = 1'b1;
        // Only the first jump seen during a stall is queued.
        if (state_q == IDLE && jt) state_d = PEND;
      end else if (state_q == PEND) begin
        stage_flush = jmask;
        state_d     = IDLE;
      end else if (jt) begin
        stage_flush = jmask;
      end else if (hazard_stall) begin
        stage_hold[0]  = 1'b1;
        stage_flush[1] = 1'b1;
        pc_hold        = 1'b1;
      end
    end
  end

`ifdef FLUSH_PERF_CNT_EN
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!rst && (|stage_flush) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (pc_hold && !(&stall_cnt_q))                stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_count = flush_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flush_sequencer.sv
// Self-checking bench for pipe_flush_sequencer: directed cases plus random stimulus vs. a rule model.
module tb_pipe_flush_sequencer;
  localparam int NS = 4;
  localparam int FS = 2;
`ifdef FLUSH_PERF_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_stall = 1'b0;
  logic          hazard_stall = 1'b0;
  logic          jump_valid = 1'b0;
  logic          jump_taken = 1'b0;
  logic [NS-1:0] stage_flush;
  logic [NS-1:0] stage_hold;
  logic          pc_hold;
  logic          flush_pending;
`ifdef FLUSH_PERF_CNT_EN
  logic [CW-1:0] flush_count;
  logic [CW-1:0] stall_count;
`endif

  pipe_flush_sequencer #(.NUM_STAGES(NS), .FLUSH_STAGES(FS), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_stall     (bus_stall),
    .hazard_stall  (hazard_stall),
    .jump_valid    (jump_valid),
    .jump_taken    (jump_taken),
    .stage_flush   (stage_flush),
    .stage_hold    (stage_hold),
    .pc_hold       (pc_hold),
    .flush_pending (flush_pending)
`ifdef FLUSH_PERF_CNT_EN
    ,
    .flush_count   (flush_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic [NS-1:0] f;
    logic [NS-1:0] h;
    logic          pc;
    logic          fp;
  } exp_t;

  // Reference: the priority list rst > bus_stall > replay > jump > hazard > normal.
  function automatic exp_t model(input bit r, input bit b, input bit hz,
                                 input bit v, input bit t, input bit pend);
    exp_t e;
    int   jm;
    jm = (1 << FS) - 1;
    e  = '0;
    if (r) begin
      e.f = {NS{1'b1}};
    end else begin
      e.fp = pend;
      if (b) begin
        e.h  = {NS{1'b1}};
        e.pc = 1'b1;
      end else if (pend || (v && t)) begin
        e.f = jm[NS-1:0];
      end else if (hz) begin
        e.h  = NS'(1);
        e.f  = NS'(2);
        e.pc = 1'b1;
      end
    end
    return e;
  endfunction

  bit pend_m = 1'b0;
  int fcnt_m = 0;
  int scnt_m = 0;

  always @(posedge clk) begin : mdl
    exp_t e;
    e = model(rst, bus_stall, hazard_stall, jump_valid, jump_taken, pend_m);
    if (rst) begin
      pend_m <= 1'b0;
      fcnt_m <= 0;
      scnt_m <= 0;
    end else begin
      if (bus_stall && jump_valid && jump_taken) pend_m <= 1'b1;
      else if (!bus_stall)                       pend_m <= 1'b0;
      if (e.f != 0 && fcnt_m < CMAX) fcnt_m <= fcnt_m + 1;
      if (e.pc && scnt_m < CMAX)     scnt_m <= scnt_m + 1;
    end
  end

  initial begin : cmp
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e = model(rst, bus_stall, hazard_stall, jump_valid, jump_taken, pend_m);
      check("m_stage_flush", 32'(stage_flush), 32'(e.f));
      check("m_stage_hold", 32'(stage_hold), 32'(e.h));
      check("m_pc_hold", 32'(pc_hold), 32'(e.pc));
      check("m_flush_pending", 32'(flush_pending), 32'(e.fp));
      check("m_exclusive", 32'(stage_flush & stage_hold), 32'(0));
`ifdef FLUSH_PERF_CNT_EN
      check("m_flush_count", 32'(flush_count), 32'(fcnt_m));
      check("m_stall_count", 32'(stall_count), 32'(scnt_m));
`endif
    end
  end

  task automatic step(input bit r, input bit b, input bit hz, input bit v, input bit t);
    @(posedge clk);
    #1;
    rst = r; bus_stall = b; hazard_stall = hz; jump_valid = v; jump_taken = t;
  endtask

  task automatic expect_out(input string name, input logic [NS-1:0] f, input logic [NS-1:0] h,
                            input logic pc, input logic fp);
    @(negedge clk);
    check({name, "_flush"}, 32'(stage_flush), 32'(f));
    check({name, "_hold"}, 32'(stage_hold), 32'(h));
    check({name, "_pc_hold"}, 32'(pc_hold), 32'(pc));
    check({name, "_pending"}, 32'(flush_pending), 32'(fp));
  endtask

  initial begin
    step(1, 0, 0, 0, 0); expect_out("rst1", 4'b1111, 4'b0000, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0); expect_out("rst2", 4'b1111, 4'b0000, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0); expect_out("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    step(0, 0, 1, 0, 0); expect_out("hazard", 4'b0010, 4'b0001, 1'b1, 1'b0);
    step(0, 0, 0, 0, 0); expect_out("hazard_after", 4'b0000, 4'b0000, 1'b0, 1'b0);

    step(0, 0, 1, 1, 1); expect_out("jump_hazard", 4'b0011, 4'b0000, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1); expect_out("taken_novalid", 4'b0000, 4'b0000, 1'b0, 1'b0);

    step(0, 1, 0, 1, 1); expect_out("bstall_c1", 4'b0000, 4'b1111, 1'b1, 1'b0);
    step(0, 1, 0, 0, 0); expect_out("bstall_c2", 4'b0000, 4'b1111, 1'b1, 1'b1);
    step(0, 1, 0, 1, 1); expect_out("bstall_c3", 4'b0000, 4'b1111, 1'b1, 1'b1);
    step(0, 0, 1, 0, 0); expect_out("replay", 4'b0011, 4'b0000, 1'b0, 1'b1);
    step(0, 0, 0, 0, 0); expect_out("replay_after", 4'b0000, 4'b0000, 1'b0, 1'b0);

    step(0, 1, 0, 1, 1); expect_out("pend_rst_c1", 4'b0000, 4'b1111, 1'b1, 1'b0);
    step(0, 1, 0, 0, 0); expect_out("pend_rst_c2", 4'b0000, 4'b1111, 1'b1, 1'b1);
    step(1, 1, 0, 0, 0); expect_out("pend_rst_c3", 4'b1111, 4'b0000, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0); expect_out("pend_rst_c4", 4'b0000, 4'b0000, 1'b0, 1'b0);

`ifdef FLUSH_PERF_CNT_EN
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_count_sat", 32'(flush_count), 32'd3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_count_2", 32'(stall_count), 32'd2);
    check("flush_count_2", 32'(flush_count), 32'd2);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
